// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the Execute stage: owns HI/LO and reports busy while a
// MULT/DIV result is held back for a fixed number of cycles before committing.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_ok_q, pend_ok_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // The full result is computed at acceptance, so later operand changes are harmless.
    logic [63:0] mul_s, mul_u;
    logic        rt_zero;
    logic [31:0] abs_a, abs_b, abs_b_safe, rt_safe;
    logic [31:0] uq_mag, ur_mag, s_quo, s_rem, u_quo, u_rem;

    always_comb begin
        mul_s      = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        mul_u      = {32'd0, rs_val} * {32'd0, rt_val};
        rt_zero    = (rt_val == 32'd0);
        abs_a      = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        abs_b      = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        abs_b_safe = rt_zero ? 32'd1 : abs_b;
        rt_safe    = rt_zero ? 32'd1 : rt_val;
        uq_mag     = abs_a / abs_b_safe;
        ur_mag     = abs_a % abs_b_safe;
        // Magnitude division then sign fix-up; 0x80000000 / -1 wraps back to 0x80000000.
        s_quo      = (rs_val[31] ^ rt_val[31]) ? (~uq_mag + 32'd1) : uq_mag;
        s_rem      = rs_val[31] ? (~ur_mag + 32'd1) : ur_mag;
        u_quo      = rs_val / rt_safe;
        u_rem      = rs_val % rt_safe;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            pend_d = mul_s; pend_ok_d = 1'b1;
                            cnt_d = MULT_N; state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_d = mul_u; pend_ok_d = 1'b1;
                            cnt_d = MULT_N; state_d = S_RUN;
                        end
                        OP_DIV: begin
                            pend_d = {s_rem, s_quo}; pend_ok_d = ~rt_zero;
                            cnt_d = DIV_N; state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_d = {u_rem, u_quo}; pend_ok_d = ~rt_zero;
                            cnt_d = DIV_N; state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            default: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    if (pend_ok_q) {hi_d, lo_d} = pend_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            pend_q    <= 64'd0;
            pend_ok_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model compared every cycle, plus
// directed literal checks and a randomized op stream.
module tb_mult_div_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: cycles left in flight, pending result computed with 64-bit math.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;
    bit          p_ok = 0;

    always @(posedge clk or negedge reset) begin
        longint          sa, sb, q, r, prod;
        longint unsigned uprod;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_ok = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_ok) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            case (op)
                3'd1: begin
                    prod = longint'($signed(rs_val)) * longint'($signed(rt_val));
                    p_hi = prod[63:32]; p_lo = prod[31:0]; p_ok = 1; m_left = 5;
                end
                3'd2: begin
                    uprod = longint'({32'd0, rs_val}) * longint'({32'd0, rt_val});
                    p_hi = uprod[63:32]; p_lo = uprod[31:0]; p_ok = 1; m_left = 5;
                end
                3'd3: begin
                    m_left = 10;
                    p_ok = (rt_val != 0);
                    if (p_ok) begin
                        sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                3'd4: begin
                    m_left = 10;
                    p_ok = (rt_val != 0);
                    if (p_ok) begin
                        p_lo = rs_val / rt_val; p_hi = rs_val % rt_val;
                    end
                end
                3'd5: m_hi = rs_val;
                3'd6: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // One-cycle start pulse presented from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 0; op = 3'($urandom_range(0, 7)); rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n >= 64) check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        start = 0; op = 0; rs_val = 0; rt_val = 0;
        reset = 0;
        // 1. Reset with random inputs
        repeat (2) begin
            #5 start = 1'($urandom); op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
            #5;
        end
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        start = 0; reset = 1;
        cmp_en = 1;
        issue(3'd5, 32'h12345678, 32'h0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // 2. MULT / MULTU
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        issue(3'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        // 3. DIV / DIVU / overflow
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'd0);

        // 4. Divide by zero leaves HI/LO alone
        issue(3'd5, 32'hAAAA0000, 32'd0);
        issue(3'd6, 32'h0000BBBB, 32'd0);
        issue(3'd3, 32'd1234, 32'd0);
        wait_idle(n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'hAAAA0000);
        check("div0_lo", lo, 32'h0000BBBB);

        // 5. Ignored start while busy, then back-to-back
        issue(3'd1, 32'd3, 32'd4);
        @(negedge clk);
        start = 1; op = 3'd6; rs_val = 32'hDEAD;
        @(negedge clk);
        start = 0;
        wait_idle(n);
        check("b2b_mult_lo", lo, 32'd12);
        check("b2b_mult_hi", hi, 32'd0);
        start = 1; op = 3'd4; rs_val = 32'd12; rt_val = 32'd5;
        @(negedge clk);
        start = 0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("b2b_divu_cycles", n, 32'd10);
        check("b2b_divu_lo", lo, 32'd2);
        check("b2b_divu_hi", hi, 32'd2);

        // 6. Asynchronous reset mid-operation
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1;
        repeat (15) @(negedge clk);
        check("nolate_hi", hi, 32'd0);
        check("nolate_lo", lo, 32'd0);

        // Randomized stream, sometimes starting while busy
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) != 0) begin
                wait_idle(n);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_idle(n);
        @(negedge clk);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
